ex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-forwarding front end of the execute stage.
- Latches decoded instruction fields each cycle and forwards results from MEM and WB stages.
- Drives operand A, operand B and the 3-bit control directly into the ALU.
- Detects load-use hazards and requests a one-cycle decode stall.

---
 rtl/ex_pkg.sv | 31 +++
 rtl/ex_operand_stage_forward_unit.sv | 32 +++
 rtl/ex_operand_stage.sv | 194 +++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute-stage operand front end.
//   - ALU operation codes driven on alu_ctrl
//   - forward-select enum produced by forward_unit
//   - packed ID/EX control bundle held in the pipeline register
package ex_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       src_a_pc;
        logic       src_b_imm;
        logic [2:0] alu_ctrl;
    } id_ex_ctrl_t;

endpackage

// File: rtl/ex_operand_stage_forward_unit.sv
// forward_unit: combinational bypass selector for one source operand.
// Ports:
//   src_addr                    register address read by the EX instruction
//   mem_reg_write, mem_rd_addr  EX/MEM writer
//   wb_reg_write,  wb_rd_addr   WB writer
//   fwd_sel                     FWD_MEM / FWD_WB / FWD_REG
// The younger MEM result wins over WB; x0 always reads the register file.
module forward_unit
    import ex_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    output fwd_sel_e          fwd_sel
);

    always_comb begin
        fwd_sel = FWD_REG;
        if (src_addr != '0) begin
            if (mem_reg_write && (mem_rd_addr == src_addr)) begin
                fwd_sel = FWD_MEM;
            end else if (wb_reg_write && (wb_rd_addr == src_addr)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register plus operand forwarding for the ALU.
// Ports:
//   clk, rst (async, active-high)
//   id_*            decoded instruction fields from decode
//   mem_*, wb_*     write-back ports of the MEM and WB stages (bypass sources)
//   flush           kill the instruction entering EX
//   alu_a/alu_b/alu_ctrl   ALU inputs
//   ex_*            registered control, destination, PC and forwarded store data
//   load_use_stall  combinational request to hold PC and IF/ID
//   perf_stall_cnt, perf_flush_cnt  saturating event counters
// Optional feature: define EX_OPERAND_PERF_EN to build the performance
// counters; otherwise both counter ports are tied to zero.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_src_a_pc,
    input  logic              id_src_b_imm,
    input  logic [2:0]        id_alu_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   wb_result,
    input  logic              flush,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [2:0]        alu_ctrl,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_store_data,
    output logic              load_use_stall,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);

    logic              vld_p1;
    id_ex_ctrl_t       ctrl_p1;
    logic [XLEN-1:0]   pc_p1;
    logic [XLEN-1:0]   imm_p1;
    logic [XLEN-1:0]   rs1_data_p1;
    logic [XLEN-1:0]   rs2_data_p1;
    logic [REG_AW-1:0] rs1_addr_p1;
    logic [REG_AW-1:0] rs2_addr_p1;
    logic [REG_AW-1:0] rd_addr_p1;

    fwd_sel_e          fwd_a_sel;
    fwd_sel_e          fwd_b_sel;
    logic [XLEN-1:0]   rs1_fwd;
    logic [XLEN-1:0]   rs2_fwd;

    // A load in EX whose destination is read by the decode instruction cannot
    // be bypassed in time; flush takes precedence because the decode
    // instruction is being discarded anyway.
    assign load_use_stall = vld_p1 & ctrl_p1.mem_read & (rd_addr_p1 != '0) &
                            id_valid & ~flush &
                            ((id_rs1_addr == rd_addr_p1) | (id_rs2_addr == rd_addr_p1));

    // ---- ID -> EX boundary ----
    // A bubble clears only the control bits; data fields keep their old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            ctrl_p1     <= '0;
            pc_p1       <= '0;
            imm_p1      <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            rs1_addr_p1 <= '0;
            rs2_addr_p1 <= '0;
            rd_addr_p1  <= '0;
        end else if (flush || load_use_stall) begin
            vld_p1            <= 1'b0;
            ctrl_p1.reg_write <= 1'b0;
            ctrl_p1.mem_read  <= 1'b0;
            ctrl_p1.mem_write <= 1'b0;
            ctrl_p1.alu_ctrl  <= ALU_ADD;
        end else begin
            vld_p1            <= id_valid;
            ctrl_p1.reg_write <= id_reg_write;
            ctrl_p1.mem_read  <= id_mem_read;
            ctrl_p1.mem_write <= id_mem_write;
            ctrl_p1.src_a_pc  <= id_src_a_pc;
            ctrl_p1.src_b_imm <= id_src_b_imm;
            ctrl_p1.alu_ctrl  <= id_alu_ctrl;
            pc_p1             <= id_pc;
            imm_p1            <= id_imm;
            rs1_data_p1       <= id_rs1_data;
            rs2_data_p1       <= id_rs2_data;
            rs1_addr_p1       <= id_rs1_addr;
            rs2_addr_p1       <= id_rs2_addr;
            rd_addr_p1        <= id_rd_addr;
        end
    end

    // ---- EX operand forwarding (combinational on registered addresses) ----
    forward_unit #(.REG_AW(REG_AW)) u_fwd_rs1 (
        .src_addr      (rs1_addr_p1),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .fwd_sel       (fwd_a_sel)
    );

    forward_unit #(.REG_AW(REG_AW)) u_fwd_rs2 (
        .src_addr      (rs2_addr_p1),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .fwd_sel       (fwd_b_sel)
    );

    always_comb begin
        rs1_fwd = rs1_data_p1;
        case (fwd_a_sel)
            FWD_MEM: rs1_fwd = mem_result;
            FWD_WB:  rs1_fwd = wb_result;
            default: rs1_fwd = rs1_data_p1;
        endcase
    end

    always_comb begin
        rs2_fwd = rs2_data_p1;
        case (fwd_b_sel)
            FWD_MEM: rs2_fwd = mem_result;
            FWD_WB:  rs2_fwd = wb_result;
            default: rs2_fwd = rs2_data_p1;
        endcase
    end

    assign alu_a         = ctrl_p1.src_a_pc  ? pc_p1  : rs1_fwd;
    assign alu_b         = ctrl_p1.src_b_imm ? imm_p1 : rs2_fwd;
    assign ex_store_data = rs2_fwd;
    assign alu_ctrl      = ctrl_p1.alu_ctrl;
    assign ex_valid      = vld_p1;
    assign ex_reg_write  = ctrl_p1.reg_write;
    assign ex_mem_read   = ctrl_p1.mem_read;
    assign ex_mem_write  = ctrl_p1.mem_write;
    assign ex_rd_addr    = rd_addr_p1;
    assign ex_pc         = pc_p1;

`ifdef EX_OPERAND_PERF_EN
    logic [31:0] stall_cnt_p1;
    logic [31:0] flush_cnt_p1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ---- performance counter boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else begin
            if (load_use_stall) begin
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
            end
            if (flush && id_valid) begin
                flush_cnt_p1 <= sat_inc(flush_cnt_p1);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_p1;
    assign perf_flush_cnt = flush_cnt_p1;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_src_a_pc, id_src_b_imm;
    logic [2:0]  id_alu_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_result;
    logic        flush;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_pc, ex_store_data;
    logic        load_use_stall;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm), .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd_addr(ex_rd_addr), .ex_pc(ex_pc),
        .ex_store_data(ex_store_data), .load_use_stall(load_use_stall),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the instruction currently sitting in EX, as a record.
    logic        m_valid, m_rw, m_mr, m_mw, m_sa, m_sb;
    logic [2:0]  m_ctrl;
    logic [4:0]  m_rs1a, m_rs2a, m_rd;
    logic [31:0] m_pc, m_imm, m_rs1d, m_rs2d;
    logic [31:0] m_stalls, m_flushes;

    function automatic logic model_stall();
        return m_valid && m_mr && (m_rd != 0) && id_valid && !flush &&
               ((id_rs1_addr == m_rd) || (id_rs2_addr == m_rd));
    endfunction

    function automatic logic [31:0] model_operand(input logic [4:0] a, input logic [31:0] regval);
        if (a != 0 && mem_reg_write && mem_rd_addr == a) return mem_result;
        if (a != 0 && wb_reg_write && wb_rd_addr == a)   return wb_result;
        return regval;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_sa <= 0; m_sb <= 0;
            m_ctrl <= 0; m_rs1a <= 0; m_rs2a <= 0; m_rd <= 0;
            m_pc <= 0; m_imm <= 0; m_rs1d <= 0; m_rs2d <= 0;
            m_stalls <= 0; m_flushes <= 0;
        end else begin
            if (model_stall()) m_stalls <= m_stalls + 1;
            if (flush && id_valid) m_flushes <= m_flushes + 1;
            if (flush || model_stall()) begin
                m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_ctrl <= 0;
            end else begin
                m_valid <= id_valid; m_rw <= id_reg_write; m_mr <= id_mem_read;
                m_mw <= id_mem_write; m_sa <= id_src_a_pc; m_sb <= id_src_b_imm;
                m_ctrl <= id_alu_ctrl; m_rs1a <= id_rs1_addr; m_rs2a <= id_rs2_addr;
                m_rd <= id_rd_addr; m_pc <= id_pc; m_imm <= id_imm;
                m_rs1d <= id_rs1_data; m_rs2d <= id_rs2_data;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("alu_a",          alu_a,          m_sa ? m_pc  : model_operand(m_rs1a, m_rs1d));
            chk("alu_b",          alu_b,          m_sb ? m_imm : model_operand(m_rs2a, m_rs2d));
            chk("ex_store_data",  ex_store_data,  model_operand(m_rs2a, m_rs2d));
            chk("alu_ctrl",       {29'd0, alu_ctrl}, {29'd0, m_ctrl});
            chk("ex_valid",       {31'd0, ex_valid},     {31'd0, m_valid});
            chk("ex_reg_write",   {31'd0, ex_reg_write}, {31'd0, m_rw});
            chk("ex_mem_read",    {31'd0, ex_mem_read},  {31'd0, m_mr});
            chk("ex_mem_write",   {31'd0, ex_mem_write}, {31'd0, m_mw});
            chk("ex_rd_addr",     {27'd0, ex_rd_addr},   {27'd0, m_rd});
            chk("ex_pc",          ex_pc,          m_pc);
            chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, model_stall()});
`ifdef EX_OPERAND_PERF_EN
            chk("perf_stall_cnt", perf_stall_cnt, m_stalls);
            chk("perf_flush_cnt", perf_flush_cnt, m_flushes);
`else
            chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
            chk("perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_src_a_pc = 0; id_src_b_imm = 0;
        id_alu_ctrl = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        mem_reg_write = 0; mem_rd_addr = 0; mem_result = 0;
        wb_reg_write = 0; wb_rd_addr = 0; wb_result = 0; flush = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        mid();
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("rst stall", {31'd0, load_use_stall}, 32'd0);
        tick();
        rst = 0;

        // ADD rs1 + imm
        id_valid = 1; id_pc = 32'h100; id_rs1_addr = 1; id_rs1_data = 5; id_imm = 7;
        id_src_b_imm = 1; id_alu_ctrl = 3'b000; id_rd_addr = 2; id_reg_write = 1;
        tick();
        id_valid = 0;
        mid();
        chk("t1 alu_a", alu_a, 32'd5);
        chk("t1 alu_b", alu_b, 32'd7);
        chk("t1 alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("t1 ex_valid", {31'd0, ex_valid}, 32'd1);

        // MEM beats WB on rs1=x3
        clear_inputs();
        id_valid = 1; id_pc = 32'h104; id_rs1_addr = 3; id_rs1_data = 32'h99;
        id_rs2_addr = 4; id_rs2_data = 32'h44; id_alu_ctrl = 3'b001; id_rd_addr = 6;
        tick();
        id_valid = 0;
        mem_reg_write = 1; mem_rd_addr = 3; mem_result = 32'h10;
        wb_reg_write = 1;  wb_rd_addr = 3;  wb_result = 32'h20;
        mid();
        chk("t2 mem prio", alu_a, 32'h10);
        chk("t2 alu_b", alu_b, 32'h44);
        chk("t2 alu_ctrl", {29'd0, alu_ctrl}, 32'd1);
        mem_reg_write = 0;
        #1;
        chk("t2 wb fwd", alu_a, 32'h20);

        // x0 is never forwarded
        clear_inputs();
        id_valid = 1; id_rs1_addr = 7; id_rs1_data = 32'h70; id_rs2_addr = 0;
        id_rs2_data = 0; id_alu_ctrl = 3'b010;
        tick();
        id_valid = 0;
        mem_reg_write = 1; mem_rd_addr = 0; mem_result = 32'hFF;
        wb_reg_write = 1;  wb_rd_addr = 0;  wb_result = 32'hEE;
        mid();
        chk("t3 x0 alu_b", alu_b, 32'd0);
        chk("t3 x0 store", ex_store_data, 32'd0);

        // load-use: load x5, then OR reads x5
        clear_inputs();
        id_valid = 1; id_rs1_addr = 1; id_rs1_data = 32'h1000; id_imm = 4;
        id_src_b_imm = 1; id_rd_addr = 5; id_mem_read = 1; id_reg_write = 1;
        tick();
        clear_inputs();
        id_valid = 1; id_rs1_addr = 2; id_rs1_data = 2; id_rs2_addr = 5;
        id_rs2_data = 32'hBAD; id_alu_ctrl = 3'b011; id_rd_addr = 8; id_reg_write = 1;
        mid();
        chk("t4 stall", {31'd0, load_use_stall}, 32'd1);
        tick();
        mid();
        chk("t4 bubble valid", {31'd0, ex_valid}, 32'd0);
        chk("t4 bubble ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("t4 bubble stall", {31'd0, load_use_stall}, 32'd0);
        tick();
        id_valid = 0;
        wb_reg_write = 1; wb_rd_addr = 5; wb_result = 32'hCAFE;
        mid();
        chk("t4 cap valid", {31'd0, ex_valid}, 32'd1);
        chk("t4 cap alu_a", alu_a, 32'd2);
        chk("t4 cap alu_b", alu_b, 32'hCAFE);
        chk("t4 cap store", ex_store_data, 32'hCAFE);
        chk("t4 cap ctrl", {29'd0, alu_ctrl}, 32'd3);

        // flush and hazard together
        clear_inputs();
        id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 9; id_mem_read = 1;
        id_reg_write = 1;
        tick();
        clear_inputs();
        id_valid = 1; id_rs1_addr = 9; id_rs2_addr = 3; id_reg_write = 1; flush = 1;
        id_alu_ctrl = 3'b100;
        mid();
        chk("t5 stall", {31'd0, load_use_stall}, 32'd0);
        tick();
        flush = 0; id_valid = 0;
        mid();
        chk("t5 bubble", {31'd0, ex_valid}, 32'd0);
        chk("t5 bubble rw", {31'd0, ex_reg_write}, 32'd0);
`ifdef EX_OPERAND_PERF_EN
        chk("t5 flush cnt", perf_flush_cnt, 32'd1);
        chk("t5 stall cnt", perf_stall_cnt, 32'd1);
`else
        chk("t5 flush cnt", perf_flush_cnt, 32'd0);
        chk("t5 stall cnt", perf_stall_cnt, 32'd0);
`endif

        // async reset mid-stream
        clear_inputs();
        id_valid = 1; id_reg_write = 1; id_alu_ctrl = 3'b100; id_rd_addr = 4;
        tick();
        mid();
        chk("t6 pre valid", {31'd0, ex_valid}, 32'd1);
        rst = 1;
        #1;
        chk("t6 async valid", {31'd0, ex_valid}, 32'd0);
        chk("t6 async rw", {31'd0, ex_reg_write}, 32'd0);
        chk("t6 async ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("t6 async perf", perf_flush_cnt, 32'd0);
        tick();
        rst = 0;

        // directed sweep over small register indices to mix hazards and bypasses
        for (int i = 0; i < 40; i++) begin
            id_valid      = (i % 5) != 4;
            id_pc         = 32'h2000 + 4 * i;
            id_rs1_addr   = 5'(i % 4);
            id_rs2_addr   = 5'((i + 1) % 4);
            id_rd_addr    = 5'((i + 2) % 4);
            id_rs1_data   = 32'h100 * i + 1;
            id_rs2_data   = 32'h100 * i + 2;
            id_imm        = 3 * i;
            id_src_a_pc   = (i % 3) == 0;
            id_src_b_imm  = (i % 2) == 1;
            id_alu_ctrl   = 3'(i % 8);
            id_reg_write  = (i % 2) == 1;
            id_mem_read   = (i % 3) == 1;
            id_mem_write  = (i % 4) == 3;
            mem_reg_write = (i % 3) != 0;
            mem_rd_addr   = 5'((i + 1) % 4);
            mem_result    = 32'hA000 + i;
            wb_reg_write  = (i % 2) == 0;
            wb_rd_addr    = 5'(i % 4);
            wb_result     = 32'hB000 + i;
            flush         = (i % 7) == 5;
            tick();
        end
        clear_inputs();
        tick();
        mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
